// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: FSM state encodings, access-size
// codes and the alignment rule used when an access is accepted.
package lsu_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // The reserved size code is reported the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return (off != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, size, sgn, addr, wdata,
        input  ready, done, err, rdata
    );

    modport slave (
        input  req, we, size, sgn, addr, wdata,
        output ready, done, err, rdata
    );
endinterface

// File: rtl/lsu_lane_merge.sv
// Little-endian byte-lane logic: inserts store data into a memory word and
// extracts/extends load data from it. Purely combinational.
module lsu_lane_merge
    import lsu_defs::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [31:0] wrep;
    logic [3:0]  lane_en;
    logic [15:0] shifted;

    // Store data is replicated across lanes so each lane only needs an enable.
    always_comb begin
        wrep    = wdata;
        lane_en = 4'b1111;
        case (size)
            SIZE_BYTE: begin
                wrep    = {4{wdata[7:0]}};
                lane_en = 4'b0001 << off;
            end
            SIZE_HALF: begin
                wrep    = {2{wdata[15:0]}};
                lane_en = off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = lane_en[gi] ? wrep[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

    assign shifted = 16'(old_word >> {off, 3'b000});

    always_comb begin
        extracted = old_word;
        case (size)
            SIZE_BYTE: extracted = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: extracted = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one access at a time against a word-wide memory,
// with read-modify-write for sub-word stores and misalignment reporting.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  cpu,
    output logic              MR,
    output logic              MW,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WD,
    input  logic [31:0]       RD
);
    lsu_state_t        state_reg, state_next;
    logic              we_reg, sgn_reg, done_reg, err_reg;
    logic [1:0]        size_reg, off_reg;
    logic [31:0]       wdata_reg, wd_reg, rdata_reg;
    logic [ADDR_W-1:0] a_reg;
    logic              accept, misaligned;
    logic [31:0]       merged, extracted;

    assign accept     = (state_reg == ST_IDLE) && cpu.req;
    assign misaligned = is_misaligned(cpu.size, cpu.addr[1:0]);

    always_comb begin
        state_next = state_reg;
        cpu.ready  = 1'b0;
        MR         = 1'b0;
        MW         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cpu.ready = 1'b1;
                if (cpu.req) begin
                    if (misaligned)
                        state_next = ST_DONE;
                    else if (cpu.we && cpu.size == SIZE_WORD)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_READ: begin
                MR         = 1'b1;
                state_next = we_reg ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                // Gated by reset so a reset landing mid-write leaves memory untouched.
                MW         = rst_n;
                state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            a_reg     <= '0;
            wd_reg    <= '0;
            we_reg    <= 1'b0;
            sgn_reg   <= 1'b0;
            size_reg  <= '0;
            off_reg   <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == ST_DONE);
            if (accept) begin
                we_reg    <= cpu.we;
                sgn_reg   <= cpu.sgn;
                size_reg  <= cpu.size;
                off_reg   <= cpu.addr[1:0];
                wdata_reg <= cpu.wdata;
                a_reg     <= {2'b00, cpu.addr[ADDR_W-1:2]};
                err_reg   <= misaligned;
                if (!misaligned && cpu.we && cpu.size == SIZE_WORD)
                    wd_reg <= cpu.wdata;
            end
            // RD is only valid during READ: capture it as a load result or merged store word.
            if (state_reg == ST_READ) begin
                if (we_reg)
                    wd_reg <= merged;
                else
                    rdata_reg <= extracted;
            end
            if (state_reg == ST_DONE)
                err_reg <= 1'b0;
        end
    end

    lsu_lane_merge u_lane_merge (
        .size      (size_reg),
        .off       (off_reg),
        .sgn       (sgn_reg),
        .old_word  (RD),
        .wdata     (wdata_reg),
        .merged    (merged),
        .extracted (extracted)
    );

    assign A         = a_reg;
    assign WD        = wd_reg;
    assign cpu.done  = done_reg;
    assign cpu.err   = err_reg;
    assign cpu.rdata = rdata_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked
// against a word-array reference memory computed with plain arithmetic.
module tb_load_store_unit;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mr, mw;
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd, rd;
    logic [31:0]       mem [64];
    logic [31:0]       ref_mem [64];
    logic [31:0]       ref_rdata;
    logic              fill, poke_en;
    logic [5:0]        poke_idx;
    logic [31:0]       poke_val;
    logic [31:0]       last_wd, last_rdata;
    logic              last_err;
    int                last_lat;
    int                checks = 0;
    int                errors = 0;
    int                txn_no = 0;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (bus),
        .MR    (mr),
        .MW    (mw),
        .A     (a),
        .WD    (wd),
        .RD    (rd)
    );

    always #5 clk = ~clk;

    assign rd = mr ? mem[a[5:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0000000C;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end else if (mw) begin
            mem[a[5:0]] <= wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [7:0] ad);
        return (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [7:0] ad);
        int          sa;
        logic [31:0] sh, v;
        sa = 8 * int'(ad[1:0]);
        sh = w >> sa;
        case (sz)
            2'd0: begin v = sh & 32'hFF;   if (sg && v[7])  v = v | 32'hFFFFFF00; end
            2'd1: begin v = sh & 32'hFFFF; if (sg && v[15]) v = v | 32'hFFFF0000; end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [7:0] ad, input logic [31:0] wdt);
        int          sa;
        logic [31:0] mask;
        sa = 8 * int'(ad[1:0]);
        if (sz == 2'd0)      mask = 32'hFF << sa;
        else if (sz == 2'd1) mask = 32'hFFFF << sa;
        else                 mask = 32'hFFFFFFFF;
        return (w & ~mask) | ((wdt << sa) & mask);
    endfunction

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic run_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [7:0] ad, input logic [31:0] wdt);
        logic        mis, seen_done;
        int          exp_lat, mr_cnt, mw_cnt, n;
        logic [31:0] exp_val;
        mis     = model_mis(sz, ad);
        exp_lat = mis ? 1 : ((!w || sz == 2'd2) ? 2 : 3);
        @(negedge clk);
        check("ready_idle", 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sgn = sg;
        bus.addr = {24'h0, ad}; bus.wdata = wdt;
        @(posedge clk); #1;
        // Scramble inputs after acceptance: the access must use the captured copy.
        bus.req = 1'b0; bus.we = ~w; bus.size = ~sz; bus.sgn = ~sg;
        bus.addr = $urandom; bus.wdata = $urandom;
        check("busy_ready", 32'(bus.ready), 32'd0);
        mr_cnt = 0; mw_cnt = 0; seen_done = 1'b0; n = 1;
        while (!seen_done && n <= 6) begin
            check("mr_mw_excl", 32'(mr & mw), 32'd0);
            if (mr) begin mr_cnt++; check("a_read", a, {26'h0, ad[7:2]}); end
            if (mw) begin mw_cnt++; last_wd = wd; check("a_write", a, {26'h0, ad[7:2]}); end
            if (bus.done) seen_done = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        last_err = bus.err; last_rdata = bus.rdata; last_lat = n;
        check("latency", n, exp_lat);
        check("err", 32'(bus.err), 32'(mis));
        check("mr_cycles", mr_cnt, (mis || (w && sz == 2'd2)) ? 0 : 1);
        check("mw_cycles", mw_cnt, (!mis && w) ? 1 : 0);
        if (!mis && !w) ref_rdata = model_load(ref_mem[ad[7:2]], sz, sg, ad);
        if (!mis && w) begin
            exp_val = model_store(ref_mem[ad[7:2]], sz, ad, wdt);
            check("wd", last_wd, exp_val);
            ref_mem[ad[7:2]] = exp_val;
        end
        check("rdata", bus.rdata, ref_rdata);
        $display("txn %0d we=%0b size=%0d sgn=%0b addr=%02h wdata=%08h lat=%0d err=%0b rdata=%08h",
                 txn_no, w, sz, sg, ad, wdt, n, last_err, last_rdata);
        txn_no++;
        // A request during the DONE cycle is ignored.
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.addr = '0;
        @(posedge clk); #1;
        check("done_ignore_ready", 32'(bus.ready), 32'd1);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        bus.req = 1'b0;
        check("mem_word", mem[ad[7:2]], ref_mem[ad[7:2]]);
    endtask

    initial begin
        logic        rw, rsg;
        logic [1:0]  rsz;
        logic [7:0]  rad;
        logic [31:0] rwd;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = '0; bus.sgn = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        fill = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        ref_rdata = '0; last_wd = '0; last_rdata = '0; last_err = 1'b0; last_lat = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0000000C;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_a", a, 32'd0);
        check("rst_wd", wd, 32'd0);
        check("rst_mr_mw", 32'({mr, mw}), 32'd0);
        @(negedge clk);
        fill = 1'b0; rst_n = 1'b1;

        run_access(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        check("ld_word_rdata", last_rdata, 32'h0000000C);
        check("ld_word_lat", last_lat, 2);
        run_access(1'b1, 2'd2, 1'b0, 8'h08, 32'hDEADBEEF);
        run_access(1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
        check("st_ld_rdata", last_rdata, 32'hDEADBEEF);
        poke(6'd3, 32'h11223344);
        run_access(1'b1, 2'd0, 1'b0, 8'h0D, 32'h000000AB);
        check("st_byte_wd", last_wd, 32'h1122AB44);
        check("st_byte_lat", last_lat, 3);
        poke(6'd3, 32'h80FF0000);
        run_access(1'b0, 2'd1, 1'b1, 8'h0E, 32'h0);
        check("ld_half_sext", last_rdata, 32'hFFFF80FF);
        run_access(1'b0, 2'd1, 1'b0, 8'h0E, 32'h0);
        check("ld_half_zext", last_rdata, 32'h000080FF);
        run_access(1'b0, 2'd2, 1'b0, 8'h06, 32'h0);
        check("mis_err", 32'(last_err), 32'd1);
        check("mis_lat", last_lat, 1);
        check("mis_rdata_kept", last_rdata, 32'h000080FF);

        // Reset during the WRITE cycle of a byte store.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.sgn = 1'b0;
        bus.addr = 32'h21; bus.wdata = 32'h55;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("rstw_read_mr", 32'(mr), 32'd1);
        @(posedge clk); #1;
        check("rstw_write_mw", 32'(mw), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_mw_gated", 32'(mw), 32'd0);
        @(posedge clk); #1;
        check("rstw_ready", 32'(bus.ready), 32'd1);
        check("rstw_done", 32'(bus.done), 32'd0);
        check("rstw_a", a, 32'd0);
        check("rstw_wd", wd, 32'd0);
        check("rstw_mem", mem[8], ref_mem[8]);
        ref_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the READ cycle of a load.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.addr = 32'h10;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("rstr_read_mr", 32'(mr), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstr_done", 32'(bus.done), 32'd0);
        check("rstr_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstr_no_late_done", 32'(bus.done), 32'd0);

        for (int t = 0; t < 150; t++) begin
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            rsg = 1'($urandom_range(0, 1));
            rad = 8'($urandom_range(0, 255));
            rwd = $urandom;
            run_access(rw, rsz, rsg, rad, rwd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
